// File: rtl/ifu_fetch_buffer_pkg.sv
// ---------------------------------------------------------------------------
// ifu_fetch_buffer_pkg
// Shared definitions for the instruction fetch front end:
//   PC_START     - default fetch PC after reset
//   INST_W       - instruction width (32)
//   REG_BUS      - architectural register / address width (64)
//   ifu_state_e  - fetch FSM state encoding (IDLE, REQ, WAIT)
//   fifo_entry_t - one queued instruction with its PC
// ---------------------------------------------------------------------------
package ifu_fetch_buffer_pkg;

    localparam logic [63:0] PC_START = 64'h8000_0000;
    localparam int          INST_W   = 32;
    localparam int          REG_BUS  = 64;

    typedef enum logic [1:0] {
        IFU_IDLE = 2'd0,
        IFU_REQ  = 2'd1,
        IFU_WAIT = 2'd2
    } ifu_state_e;

    typedef struct packed {
        logic [REG_BUS-1:0] pc;
        logic [INST_W-1:0]  inst;
    } fifo_entry_t;

endpackage

// File: rtl/ifu_inst_fifo.sv
// ---------------------------------------------------------------------------
// ifu_inst_fifo
// Small instruction queue feeding decode. Up to two entries may be written
// per cycle (push0 lands before push1), one entry is read per cycle.
// Ports:
//   clk, rst          - clock, asynchronous active-low reset
//   i_flush           - synchronous flush, wins over push and pop
//   i_push0/i_data0   - first (older) write
//   i_push1/i_data1   - second (younger) write
//   i_pop             - consume the head entry
//   o_head            - head entry {pc, inst}
//   o_valid           - queue not empty
//   o_free            - number of free entries
// ---------------------------------------------------------------------------
module ifu_inst_fifo
    import ifu_fetch_buffer_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   i_flush,
    input  logic                   i_push0,
    input  fifo_entry_t            i_data0,
    input  logic                   i_push1,
    input  fifo_entry_t            i_data1,
    input  logic                   i_pop,
    output fifo_entry_t            o_head,
    output logic                   o_valid,
    output logic [$clog2(DEPTH):0] o_free
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    fifo_entry_t      w_entries [DEPTH];
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W-1:0] r_wr_ptr;
    logic [CNT_W-1:0] r_count;
    logic [PTR_W-1:0] w_slot1;
    logic [CNT_W-1:0] w_push_n;
    logic             w_pop;

    // push1 goes to the slot after push0 when both are written together
    assign w_slot1  = i_push0 ? (r_wr_ptr + PTR_W'(1)) : r_wr_ptr;
    assign w_push_n = CNT_W'(i_push0) + CNT_W'(i_push1);
    assign w_pop    = i_pop && (r_count != '0);

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_entry
            fifo_entry_t r_entry;
            logic        w_we0;
            logic        w_we1;

            assign w_we0 = !i_flush && i_push0 && (r_wr_ptr == PTR_W'(gi));
            assign w_we1 = !i_flush && i_push1 && (w_slot1 == PTR_W'(gi));

            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    r_entry <= '0;
                end else if (w_we1) begin
                    r_entry <= i_data1;
                end else if (w_we0) begin
                    r_entry <= i_data0;
                end
            end

            assign w_entries[gi] = r_entry;
        end
    endgenerate

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else if (i_flush) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            // pointers wrap naturally because DEPTH is a power of two
            r_wr_ptr <= r_wr_ptr + w_push_n[PTR_W-1:0];
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            r_count <= r_count + w_push_n - CNT_W'(w_pop);
        end
    end

    assign o_head  = w_entries[r_rd_ptr];
    assign o_valid = (r_count != '0);
    assign o_free  = CNT_W'(DEPTH) - r_count;

endmodule

// File: rtl/ifu_fetch_buffer.sv
// ---------------------------------------------------------------------------
// ifu_fetch_buffer
// Fetch front end upstream of decode. Issues aligned 64-bit reads, splits
// each returned doubleword into two 32-bit instructions, queues them with
// their PCs and presents one per cycle to decode. Redirects flush the queue
// and kill any fetch that is still in flight.
// Ports:
//   clk, rst                        - clock, asynchronous active-low reset
//   redirect_valid, redirect_pc     - restart fetch at redirect_pc (bits [1:0] ignored)
//   mem_req_valid/ready/addr        - doubleword read request
//   mem_resp_valid/data             - read response (one per accepted request)
//   out_valid/ready, out_inst/pc    - instruction stream to decode
// ---------------------------------------------------------------------------
module ifu_fetch_buffer #(
    parameter logic [63:0] PC_START = ifu_fetch_buffer_pkg::PC_START,
    parameter int          DEPTH    = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        redirect_valid,
    input  logic [63:0] redirect_pc,
    output logic        mem_req_valid,
    output logic [63:0] mem_req_addr,
    input  logic        mem_req_ready,
    input  logic        mem_resp_valid,
    input  logic [63:0] mem_resp_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_inst,
    output logic [63:0] out_pc
);

    import ifu_fetch_buffer_pkg::*;

    localparam int CNT_W = $clog2(DEPTH) + 1;

    ifu_state_e       r_state;
    logic [63:0]      r_fetch_pc;
    logic             r_kill;
    logic             r_mem_req_valid;
    logic [63:0]      r_mem_req_addr;

    logic [63:0]      w_redirect_pc;
    logic [63:0]      w_line_base;
    logic             w_resp_take;
    logic             w_push0;
    logic             w_push1;
    logic             w_pop;
    fifo_entry_t      w_data0;
    fifo_entry_t      w_data1;
    fifo_entry_t      w_head;
    logic             w_fifo_valid;
    logic [CNT_W-1:0] w_free;

    assign w_redirect_pc = redirect_pc & ~64'h3;
    assign w_line_base   = r_fetch_pc & ~64'h7;

    // A response is only kept if it belongs to the current fetch stream and
    // no redirect lands in the same cycle.
    assign w_resp_take = (r_state == IFU_WAIT) && mem_resp_valid && !r_kill && !redirect_valid;
    // Low word is skipped when fetch started on the upper half of the line.
    assign w_push0     = w_resp_take && !r_fetch_pc[2];
    assign w_push1     = w_resp_take;
    assign w_data0     = {r_fetch_pc, mem_resp_data[31:0]};
    assign w_data1     = {w_line_base | 64'h4, mem_resp_data[63:32]};
    assign w_pop       = w_fifo_valid && out_ready && !redirect_valid;

    ifu_inst_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_flush (redirect_valid),
        .i_push0 (w_push0),
        .i_data0 (w_data0),
        .i_push1 (w_push1),
        .i_data1 (w_data1),
        .i_pop   (w_pop),
        .o_head  (w_head),
        .o_valid (w_fifo_valid),
        .o_free  (w_free)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state         <= IFU_IDLE;
            r_fetch_pc      <= PC_START;
            r_kill          <= 1'b0;
            r_mem_req_valid <= 1'b0;
            r_mem_req_addr  <= '0;
        end else begin
            if (redirect_valid) begin
                r_fetch_pc <= w_redirect_pc;
            end
            case (r_state)
                IFU_IDLE: begin
                    // two free slots guarantee the response can always be pushed
                    if (!redirect_valid && (w_free >= CNT_W'(2))) begin
                        r_state         <= IFU_REQ;
                        r_mem_req_valid <= 1'b1;
                        r_mem_req_addr  <= w_line_base;
                    end
                end
                IFU_REQ: begin
                    // request cannot be withdrawn; mark its response as stale
                    if (redirect_valid) begin
                        r_kill <= 1'b1;
                    end
                    if (mem_req_ready) begin
                        r_mem_req_valid <= 1'b0;
                        r_state         <= IFU_WAIT;
                    end
                end
                IFU_WAIT: begin
                    if (mem_resp_valid) begin
                        r_kill  <= 1'b0;
                        r_state <= IFU_IDLE;
                        if (!r_kill && !redirect_valid) begin
                            r_fetch_pc <= w_line_base + 64'd8;
                        end
                    end else if (redirect_valid) begin
                        r_kill <= 1'b1;
                    end
                end
                default: begin
                    r_state         <= IFU_IDLE;
                    r_mem_req_valid <= 1'b0;
                end
            endcase
        end
    end

    assign mem_req_valid = r_mem_req_valid;
    assign mem_req_addr  = r_mem_req_addr;
    assign out_valid     = w_fifo_valid;
    assign out_inst      = w_head.inst;
    assign out_pc        = w_head.pc;

endmodule

// File: tb/tb_ifu_fetch_buffer.sv
// ---------------------------------------------------------------------------
// tb_ifu_fetch_buffer
// Drives the fetch buffer against a memory model whose contents are a fixed
// function of the address. Every instruction handed to decode is compared
// with the next PC of the expected sequential stream (restarted on each
// redirect) and with the memory contents at that PC.
// ---------------------------------------------------------------------------
module tb_ifu_fetch_buffer;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [63:0] redirect_pc = '0;
    logic        mem_req_valid;
    logic [63:0] mem_req_addr;
    logic        mem_req_ready = 1'b0;
    logic        mem_resp_valid = 1'b0;
    logic [63:0] mem_resp_data = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_inst;
    logic [63:0] out_pc;

    always #5 clk = ~clk;

    ifu_fetch_buffer #(
        .PC_START (64'h8000_0000),
        .DEPTH    (4)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .mem_req_valid  (mem_req_valid),
        .mem_req_addr   (mem_req_addr),
        .mem_req_ready  (mem_req_ready),
        .mem_resp_valid (mem_resp_valid),
        .mem_resp_data  (mem_resp_data),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_inst       (out_inst),
        .out_pc         (out_pc)
    );

    typedef struct {
        logic [63:0] addr;
        int          delay;
    } pend_t;

    typedef struct {
        logic [63:0] pc;
        logic [31:0] inst;
    } out_t;

    typedef struct {
        logic [63:0] redir_pc;
        logic [63:0] exp_req0;
        logic [63:0] exp_out_pc;
        logic [31:0] exp_out_inst;
        logic [63:0] exp_req1;
    } vec_t;

    int          n_checks = 0;
    int          n_fail   = 0;
    pend_t       pend_q[$];
    logic [63:0] req_log[$];
    out_t        out_log[$];
    int          mem_lat      = 1;
    int          mem_rand_lat = 0;
    int          ready_mode   = 1;   // 0 never, 1 always, 2 random
    logic [63:0] exp_pc       = 64'h8000_0000;
    vec_t        vecs[5];

    // Memory contents: two fixed words at the reset vector, a hash elsewhere.
    function automatic logic [31:0] inst_at(input logic [63:0] pc);
        if (pc == 64'h8000_0000) return 32'h0000_0013;
        if (pc == 64'h8000_0004) return 32'h0010_0093;
        return pc[31:0] ^ pc[63:32] ^ 32'hC3A5_0000;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] want);
        n_checks++;
        if (act !== want) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, want);
        end
    endtask

    // One clock: serve memory, record handshakes for the coming edge, advance
    // to the next falling edge and check cycle-level invariants.
    task automatic cycle();
        pend_t       p;
        logic        redir;
        logic        hold_req;
        logic [63:0] held_addr;
        int          lat;

        if (pend_q.size() != 0 && pend_q[0].delay == 0) begin
            mem_resp_valid = 1'b1;
            mem_resp_data  = {inst_at(pend_q[0].addr + 64'd4), inst_at(pend_q[0].addr)};
            void'(pend_q.pop_front());
        end else begin
            mem_resp_valid = 1'b0;
            mem_resp_data  = 64'h0BAD_F00D_0BAD_F00D;
            if (pend_q.size() != 0) begin
                p = pend_q[0];
                p.delay--;
                pend_q[0] = p;
            end
        end

        case (ready_mode)
            0:       mem_req_ready = 1'b0;
            1:       mem_req_ready = 1'b1;
            default: mem_req_ready = ($urandom_range(0, 1) == 1);
        endcase

        if (mem_req_valid && mem_req_ready) begin
            chk("req_single_outstanding", 64'(pend_q.size()), 64'd0);
            chk("req_addr_aligned", 64'(mem_req_addr[2:0]), 64'd0);
            req_log.push_back(mem_req_addr);
            lat = (mem_rand_lat != 0) ? int'($urandom_range(1, 4)) : mem_lat;
            p.addr  = mem_req_addr;
            p.delay = lat - 1;
            pend_q.push_back(p);
        end

        if (out_valid && out_ready && !redirect_valid) begin
            out_t o;
            o.pc   = out_pc;
            o.inst = out_inst;
            $display("OUT pc=0x%016h inst=0x%08h", out_pc, out_inst);
            chk("out_pc_stream", out_pc, exp_pc);
            chk("out_inst_stream", 64'(out_inst), 64'(inst_at(exp_pc)));
            out_log.push_back(o);
            exp_pc = exp_pc + 64'd4;
        end

        redir = redirect_valid;
        if (redirect_valid) exp_pc = redirect_pc & ~64'h3;
        hold_req  = mem_req_valid && !mem_req_ready;
        held_addr = mem_req_addr;

        @(posedge clk);
        @(negedge clk);

        if (redir) chk("flush_out_valid", 64'(out_valid), 64'd0);
        if (hold_req) begin
            chk("req_held_valid", 64'(mem_req_valid), 64'd1);
            chk("req_held_addr", mem_req_addr, held_addr);
        end
    endtask

    task automatic do_reset();
        rst            = 1'b0;
        redirect_valid = 1'b0;
        out_ready      = 1'b0;
        mem_req_ready  = 1'b0;
        mem_resp_valid = 1'b0;
        mem_rand_lat   = 0;
        mem_lat        = 1;
        ready_mode     = 1;
        pend_q.delete();
        req_log.delete();
        out_log.delete();
        exp_pc = 64'h8000_0000;
        repeat (2) @(negedge clk);
        chk("rst_mem_req_valid", 64'(mem_req_valid), 64'd0);
        chk("rst_mem_req_addr", mem_req_addr, 64'd0);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_inst", 64'(out_inst), 64'd0);
        chk("rst_out_pc", out_pc, 64'd0);
        rst = 1'b1;
    endtask

    task automatic run_outs(input int n, input int budget, input string tag);
        int c = 0;
        while (out_log.size() < n && c < budget) begin
            cycle();
            c++;
        end
        chk(tag, 64'(out_log.size() >= n), 64'd1);
    endtask

    task automatic run_reqs(input int n, input int budget, input string tag);
        int c = 0;
        while (req_log.size() < n && c < budget) begin
            cycle();
            c++;
        end
        chk(tag, 64'(req_log.size() >= n), 64'd1);
    endtask

    task automatic run_valid(input int budget, input string tag);
        int c = 0;
        while (!out_valid && c < budget) begin
            cycle();
            c++;
        end
        chk(tag, 64'(out_valid), 64'd1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{64'h8000_0104, 64'h8000_0100, 64'h8000_0104, inst_at(64'h8000_0104), 64'h8000_0108};
        vecs[1] = '{64'h8000_0200, 64'h8000_0200, 64'h8000_0200, inst_at(64'h8000_0200), 64'h8000_0208};
        vecs[2] = '{64'h8000_0107, 64'h8000_0100, 64'h8000_0104, inst_at(64'h8000_0104), 64'h8000_0108};
        vecs[3] = '{64'hFFFF_FFFF_FFFF_FFFC, 64'hFFFF_FFFF_FFFF_FFF8, 64'hFFFF_FFFF_FFFF_FFFC,
                    inst_at(64'hFFFF_FFFF_FFFF_FFFC), 64'h0};
        vecs[4] = '{64'h0000_0000_0000_1002, 64'h1000, 64'h1000, inst_at(64'h1000), 64'h1008};

        @(negedge clk);

        // Straight-line fetch from the reset vector.
        do_reset();
        out_ready = 1'b1;
        run_outs(2, 50, "boot_outs_timeout");
        chk("boot_req0", req_log[0], 64'h8000_0000);
        chk("boot_out0_pc", out_log[0].pc, 64'h8000_0000);
        chk("boot_out0_inst", 64'(out_log[0].inst), 64'h0000_0013);
        chk("boot_out1_pc", out_log[1].pc, 64'h8000_0004);
        chk("boot_out1_inst", 64'(out_log[1].inst), 64'h0010_0093);
        run_reqs(2, 50, "boot_req_timeout");
        chk("boot_req1", req_log[1], 64'h8000_0008);

        // Redirect while idle, table driven.
        for (int v = 0; v < 5; v++) begin
            do_reset();
            out_ready      = 1'b1;
            redirect_valid = 1'b1;
            redirect_pc    = vecs[v].redir_pc;
            cycle();
            redirect_valid = 1'b0;
            run_outs(1, 60, "vec_out_timeout");
            run_reqs(2, 60, "vec_req_timeout");
            chk("vec_req0", req_log[0], vecs[v].exp_req0);
            chk("vec_out_pc", out_log[0].pc, vecs[v].exp_out_pc);
            chk("vec_out_inst", 64'(out_log[0].inst), 64'(vecs[v].exp_out_inst));
            chk("vec_req1", req_log[1], vecs[v].exp_req1);
        end

        // Back-pressure: queue fills and fetch stalls until two slots free up.
        do_reset();
        repeat (20) cycle();
        chk("bp_req_count", 64'(req_log.size()), 64'd2);
        chk("bp_out_valid", 64'(out_valid), 64'd1);
        chk("bp_no_req_full", 64'(mem_req_valid), 64'd0);
        out_ready = 1'b1;
        cycle();
        out_ready = 1'b0;
        chk("bp_pop1", 64'(out_log.size()), 64'd1);
        repeat (5) cycle();
        chk("bp_no_req_one_free", 64'(mem_req_valid), 64'd0);
        chk("bp_req_count2", 64'(req_log.size()), 64'd2);
        out_ready = 1'b1;
        cycle();
        out_ready = 1'b0;
        chk("bp_req_not_yet", 64'(mem_req_valid), 64'd0);
        cycle();
        chk("bp_req_resumes", 64'(mem_req_valid), 64'd1);

        // Redirect while waiting on a slow response.
        do_reset();
        out_ready = 1'b1;
        mem_lat   = 4;
        run_reqs(1, 20, "wait_req_timeout");
        redirect_valid = 1'b1;
        redirect_pc    = 64'h8000_0200;
        cycle();
        redirect_valid = 1'b0;
        run_outs(1, 60, "wait_out_timeout");
        chk("wait_req1", req_log[1], 64'h8000_0200);
        chk("wait_first_out_pc", out_log[0].pc, 64'h8000_0200);

        // Redirect with two queued entries and decode ready in the same cycle.
        do_reset();
        run_valid(30, "flush_fill_timeout");
        redirect_valid = 1'b1;
        redirect_pc    = 64'h8000_0300;
        out_ready      = 1'b1;
        cycle();
        redirect_valid = 1'b0;
        run_outs(1, 60, "flush_out_timeout");
        chk("flush_next_pc", out_log[0].pc, 64'h8000_0300);

        // Asynchronous reset while a request is pending.
        do_reset();
        run_valid(30, "areset_fill_timeout");
        ready_mode = 0;
        cycle();
        chk("areset_pre_req", 64'(mem_req_valid), 64'd1);
        chk("areset_pre_valid", 64'(out_valid), 64'd1);
        #2;
        rst = 1'b0;
        #1;
        chk("areset_req_drop", 64'(mem_req_valid), 64'd0);
        chk("areset_valid_drop", 64'(out_valid), 64'd0);
        @(negedge clk);
        do_reset();
        run_reqs(1, 20, "areset_req_timeout");
        chk("areset_first_req", req_log[0], 64'h8000_0000);

        // Randomised traffic against the stream model.
        do_reset();
        ready_mode   = 2;
        mem_rand_lat = 1;
        for (int c = 0; c < 3000; c++) begin
            out_ready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 19) == 0) begin
                redirect_valid = 1'b1;
                redirect_pc    = 64'h8000_0000 + 64'($urandom_range(0, 1023));
            end else begin
                redirect_valid = 1'b0;
            end
            cycle();
        end
        redirect_valid = 1'b0;
        chk("rand_progress", 64'(out_log.size() > 200), 64'd1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
